// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared encodings, defaults and divisor clamp for the tick controller
package tick_pkg;

    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned DIV_DEFAULT_DEF = 32'd15000000;
    localparam int          CLAMP_W         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } tick_state_e;

    // A zero divisor would never reach a period end, so it is promoted to 1.
    function automatic logic [CLAMP_W-1:0] clamp_min1(input logic [CLAMP_W-1:0] x);
        return (x == '0) ? CLAMP_W'(1) : x;
    endfunction

endpackage

// File: rtl/tick_ctrl_if.sv
// rtl/tick_ctrl_if.sv - control and status bundle between the time base and its user
interface tick_ctrl_if
    import tick_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             run;
    logic             step;
    logic             div_load;
    logic [CNT_W-1:0] div_in;
    logic             tick;
    logic             clk_div;
    logic [1:0]       state;
    logic [CNT_W-1:0] div_active;

    modport master (
        output run, step, div_load, div_in,
        input  tick, clk_div, state, div_active
    );

    modport slave (
        input  run, step, div_load, div_in,
        output tick, clk_div, state, div_active
    );
endinterface

// File: rtl/period_counter.sv
// rtl/period_counter.sv - clearable up-counter that wraps to 0 after limit-1
module period_counter
    import tick_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    assign wrap = (count == limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - run/pause/single-step tick generator with glitch-free period updates
module tick_ctrl
    import tick_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tick_ctrl_if.slave  bus
);

    tick_state_e      state_q;
    tick_state_e      state_d;
    logic [CNT_W-1:0] div_active_q;
    logic [CNT_W-1:0] div_pending_q;
    logic             pend_valid_q;
    logic             tick_q;
    logic             clk_div_q;

    logic             clear;
    logic             boundary;
    logic             apply;
    logic             wrap;
    logic [CNT_W-1:0] cnt_unused;
    logic [CNT_W-1:0] div_in_clamped;

    assign div_in_clamped = CNT_W'(clamp_min1(CLAMP_W'(bus.div_in)));

    period_counter #(.CNT_W(CNT_W)) u_period_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (state_q != IDLE),
        .limit  (div_active_q),
        .count  (cnt_unused),
        .wrap   (wrap)
    );

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        boundary = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (bus.run) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                // Dropping run wins over a coincident period end: no tick.
                if (!bus.run) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (wrap) begin
                    boundary = 1'b1;
                end
            end
            STEP: begin
                if (bus.run) begin
                    state_d = RUN;
                end
                if (wrap) begin
                    boundary = 1'b1;
                    if (!bus.run) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    // A pending divisor lands only when no period is in flight or one just ended.
    assign apply = pend_valid_q && ((state_q == IDLE) || boundary);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            tick_q        <= 1'b0;
            clk_div_q     <= 1'b0;
            div_active_q  <= CNT_W'(DIV_DEFAULT);
            div_pending_q <= '0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= boundary;
            if (boundary) begin
                clk_div_q <= ~clk_div_q;
            end
            if (apply) begin
                div_active_q <= div_pending_q;
            end
            if (bus.div_load) begin
                div_pending_q <= div_in_clamped;
                pend_valid_q  <= 1'b1;
            end else if (apply) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign bus.tick       = tick_q;
    assign bus.clk_div    = clk_div_q;
    assign bus.state      = state_q;
    assign bus.div_active = div_active_q;

endmodule

// File: doc/tick_ctrl.md
# tick_ctrl

Run/pause/single-step controller for the board time base. It replaces the free-running fixed divider in front of slow datapaths such as the factorial-sum sequencer and display. Outputs:
- `tick`, a one-cycle clock enable for downstream logic.
- `clk_div`, a square wave for LEDs.

The period is programmable at runtime, and a new value takes effect only on a period boundary so the period is never glitched.

## Interface
Parameters:
- `CNT_W`, default 32: counter and divisor width.
- `DIV_DEFAULT`, default 15000000: divisor loaded at reset, in clk cycles per tick.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-low.
- `run`  in  1  level; 1 = free-run, 0 = pause.
- `step`  in  1  single-cycle pulse; requests exactly one tick while paused.
- `div_load`  in  1  single-cycle strobe; captures `div_in`.
- `div_in`  in  CNT_W  requested period in clk cycles; 0 is treated as 1.
- `tick`  out  1  registered one-cycle enable at each period end.
- `clk_div`  out  1  registered; toggles on every tick.
- `state`  out  2  current FSM state: IDLE=0, RUN=1, STEP=2.
- `div_active`  out  CNT_W  divisor currently in use.

## Operation
Reset, on a clk edge with `rst`=0, sets:
- state=IDLE, counter=0, tick=0, clk_div=0.
- div_active=DIV_DEFAULT.
- Pending-divisor valid flag cleared.

FSM:
- **IDLE**
  - Counter held at 0; tick=0.
  - `run`=1 goes to RUN.
  - Otherwise a `step` pulse goes to STEP.
  - `run` has priority over `step` when both are high.
- **RUN**
  - Counter increments every cycle.
  - When counter==div_active-1: counter<=0, tick<=1, clk_div<=~clk_div.
  - `run`=0 goes to IDLE immediately: counter cleared, no tick issued, clk_div holds its level.
  - `step` is ignored.
- **STEP**
  - Counts exactly like RUN.
  - At the period end it issues the tick and returns to IDLE on the same edge.
  - `run`=1 during STEP moves to RUN with the count preserved (no restart).
  - Further `step` pulses are ignored.

Divisor update:
- `div_load` writes the clamped `div_in` (max(div_in,1)) into `div_pending` and sets the valid flag.
- In IDLE, the pending value is copied to div_active on the next edge.
- In RUN or STEP, it is copied on the boundary edge (the edge where tick<=1). The period just ending used the old divisor.
- If `div_load` arrives on the boundary cycle itself, it is captured into pending and applied at the following boundary.
- A later `div_load` overwrites an unapplied pending value: last writer wins.

Arithmetic:
- Comparison is against div_active-1 at CNT_W bits.
- Because of the clamp, div_active is never 0 and the counter never wraps past div_active-1.
- div_active=1 gives tick held high continuously in RUN and clk_div toggling every cycle.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Entering RUN or STEP at edge E0 (counter=0 after E0): first tick is high in the cycle after edge E0+div_active, then every div_active cycles.
- Tick is high for exactly one cycle unless div_active=1.
- `run` falling: state=IDLE after the next edge. A tick that would have occurred on that same edge is suppressed.
- `step` latency: STEP is entered 1 edge after the pulse; the tick follows div_active edges later.
- `state` and `div_active` update on the same edge as the transition or apply.
- Reset asserted mid-period aborts the period on the next edge, with the reset values above.

## Structure
- Shared package `tick_pkg`:
  - state encoding constants IDLE/RUN/STEP (2-bit);
  - `CNT_W` and `DIV_DEFAULT` defaults;
  - clamp function max(x,1).
- Sub-module `period_counter`:
  - inputs: clear, enable, limit;
  - outputs: count, `wrap` (high when count==limit-1);
  - the FSM, divisor registers and clk_div toggle sit in `tick_ctrl`.

## Test plan
- Reset, then `run`=1 with DIV_DEFAULT overridden to 4:
  - ticks every 4 cycles, the first 4 edges after RUN entry;
  - clk_div toggles at each tick;
  - state=1.
- Paused with div 5, one `step` pulse:
  - STEP for 5 cycles, exactly one tick, then IDLE with counter=0;
  - a second `step` during STEP is ignored.
- RUN with div 10, `div_load` of 3 at count 4:
  - remaining period still 10 cycles;
  - div_active=3 on the boundary edge, then ticks every 3 cycles.
- `div_load` of `div_in`=0 in IDLE: div_active=1, and RUN gives tick constantly high.
- `run` dropped on the cycle where count==div_active-1:
  - no tick, state=IDLE, clk_div unchanged;
  - raising `run` again restarts from count 0.
- `rst`=0 pulse mid-RUN with div 8 at count 5:
  - next edge: tick=0, clk_div=0, state=0, div_active=DIV_DEFAULT, pending cleared.
